// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
//   cmp_state_t : controller states (IDLE / RUN / DONE)
//   cmp_flags_t : cascade / result flag triple {eq, gt, lt}
//   CMP_IDX_W   : bit-index register width for the default 32-bit operand
//   idx_width() : bit-index register width for any operand width
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_flags_t;

    localparam int unsigned CMP_WIDTH = 32;
    localparam int unsigned CMP_IDX_W = $clog2(CMP_WIDTH);

    // Width needed to hold a bit index 0..w-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_cmp_step.sv
// One-bit cascade step of the magnitude comparator (purely combinational).
// Ports:
//   a, b : operand bit pair for the current position
//   cur  : incoming cascade flags {eq, gt, lt}
//   nxt  : outgoing cascade flags after folding in this bit pair
module seq_cmp_step
    import cmp_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  cmp_flags_t cur,
    output cmp_flags_t nxt
);

    // Once a difference has been seen, eq stays low and gt/lt stay latched;
    // only the first differing bit (while still equal) can set gt or lt.
    assign nxt.eq = cur.eq & ~(a ^ b);
    assign nxt.gt = cur.gt | (a & ~b & cur.eq);
    assign nxt.lt = cur.lt | (~a & b & cur.eq);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle, bit-serial magnitude comparator (MSB first), signed or
// unsigned, with a start/done handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no compare yet since reset; ready for start_i
// RUN   | one bit pair folded into the cascade per clock
// DONE  | results valid (done_o pulses on entry); ready for start_i
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   start_i  : compare request, accepted only while ready_o=1
//   op_a_i   : operand A, sampled on the accept edge
//   op_b_i   : operand B, sampled on the accept edge
//   signed_i : 1 = two's-complement compare, sampled on the accept edge
//   ready_o  : block can accept start_i
//   done_o   : one-cycle pulse, results valid
//   eq_o     : A == B
//   gt_o     : A >  B
//   lt_o     : A <  B
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             signed_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    cmp_state_t       state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             sgn_q;
    logic [IDX_W-1:0] idx_q;
    cmp_flags_t       flags_q;
    cmp_flags_t       flags_nxt;
    cmp_flags_t       res_q;
    logic             done_q;
    logic             ready_q;

    logic             swap;
    logic             bit_a;
    logic             bit_b;
    logic             finish;

    // The sign bit carries negative weight, so in a signed compare a set
    // sign bit makes the operand smaller: swapping the pair at the MSB
    // step is all that is needed.
    assign swap  = sgn_q && (idx_q == IDX_TOP);
    assign bit_a = swap ? sb_q[WIDTH-1] : sa_q[WIDTH-1];
    assign bit_b = swap ? sa_q[WIDTH-1] : sb_q[WIDTH-1];

    seq_cmp_step u_step (
        .a   (bit_a),
        .b   (bit_b),
        .cur (flags_q),
        .nxt (flags_nxt)
    );

    assign finish = (idx_q == '0) || (EARLY_EXIT && !flags_nxt.eq);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            flags_q <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        sa_q    <= op_a_i;
                        sb_q    <= op_b_i;
                        sgn_q   <= signed_i;
                        idx_q   <= IDX_TOP;
                        flags_q <= '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    flags_q <= flags_nxt;
                    sa_q    <= {sa_q[WIDTH-2:0], 1'b0};
                    sb_q    <= {sb_q[WIDTH-2:0], 1'b0};
                    idx_q   <= idx_q - IDX_W'(1);
                    if (finish) begin
                        res_q   <= flags_nxt;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign eq_o    = res_q.eq;
    assign gt_o    = res_q.gt;
    assign lt_o    = res_q.lt;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: three instances (8-bit full-length,
// 8-bit early-exit, 32-bit full-length) checked every cycle against a
// cycle-count/arithmetic reference model, plus literal directed checks.
module tb_seq_mag_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0]       st = '0;
    logic [2:0]       sg = '0;
    logic [2:0][31:0] a_in = '0;
    logic [2:0][31:0] b_in = '0;
    logic [2:0]       rdy, dn, eq, gt, lt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full8 (
        .clk_i(clk), .rst_i(rst), .start_i(st[0]),
        .op_a_i(a_in[0][7:0]), .op_b_i(b_in[0][7:0]), .signed_i(sg[0]),
        .ready_o(rdy[0]), .done_o(dn[0]), .eq_o(eq[0]), .gt_o(gt[0]), .lt_o(lt[0])
    );

    seq_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early8 (
        .clk_i(clk), .rst_i(rst), .start_i(st[1]),
        .op_a_i(a_in[1][7:0]), .op_b_i(b_in[1][7:0]), .signed_i(sg[1]),
        .ready_o(rdy[1]), .done_o(dn[1]), .eq_o(eq[1]), .gt_o(gt[1]), .lt_o(lt[1])
    );

    seq_mag_comparator #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_full32 (
        .clk_i(clk), .rst_i(rst), .start_i(st[2]),
        .op_a_i(a_in[2]), .op_b_i(b_in[2]), .signed_i(sg[2]),
        .ready_o(rdy[2]), .done_o(dn[2]), .eq_o(eq[2]), .gt_o(gt[2]), .lt_o(lt[2])
    );

    function automatic int width_of(input int d);
        return (d == 2) ? 32 : 8;
    endfunction

    function automatic bit early_of(input int d);
        return (d == 1);
    endfunction

    // Reference: numeric compare of the operand values, latency from the
    // position of the first differing bit. f = {eq, gt, lt}.
    task automatic ref_cmp(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input bit ee,
                           output logic [2:0] f, output int lat);
        longint mask, va, vb;
        mask = (longint'(1) << w) - 1;
        va = longint'(a) & mask;
        vb = longint'(b) & mask;
        if (sgn && a[w-1]) va = va - (longint'(1) << w);
        if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
        if (va == vb)     f = 3'b100;
        else if (va > vb) f = 3'b010;
        else              f = 3'b001;
        lat = w;
        if (ee && va != vb) begin
            for (int k = w - 1; k >= 0; k--) begin
                if (a[k] != b[k]) begin
                    lat = w - k;
                    break;
                end
            end
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model, advanced on every clock edge ----------------
    int         m_busy [3] = '{0, 0, 0};
    logic [2:0] m_pend [3];
    logic [2:0] m_rdy = '1;
    logic [2:0] m_dn  = '0;
    logic [2:0] m_eq  = '0;
    logic [2:0] m_gt  = '0;
    logic [2:0] m_lt  = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    m_busy[d] = 0;
                    m_rdy[d] = 1'b1;
                    m_dn[d] = 1'b0;
                    m_eq[d] = 1'b0;
                    m_gt[d] = 1'b0;
                    m_lt[d] = 1'b0;
                end else if (m_busy[d] > 0) begin
                    m_busy[d]--;
                    if (m_busy[d] == 0) begin
                        m_dn[d]  = 1'b1;
                        m_rdy[d] = 1'b1;
                        {m_eq[d], m_gt[d], m_lt[d]} = m_pend[d];
                    end
                end else begin
                    m_dn[d] = 1'b0;
                    if (st[d]) begin
                        int lat;
                        ref_cmp(width_of(d), a_in[d], b_in[d], sg[d], early_of(d), m_pend[d], lat);
                        m_busy[d] = lat;
                        m_rdy[d]  = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 3; d++) begin
                    chk_int($sformatf("dut%0d ready", d), int'(rdy[d]), int'(m_rdy[d]));
                    chk_int($sformatf("dut%0d done", d),  int'(dn[d]),  int'(m_dn[d]));
                    chk_int($sformatf("dut%0d eq", d),    int'(eq[d]),  int'(m_eq[d]));
                    chk_int($sformatf("dut%0d gt", d),    int'(gt[d]),  int'(m_gt[d]));
                    chk_int($sformatf("dut%0d lt", d),    int'(lt[d]),  int'(m_lt[d]));
                    if (dn[d])
                        chk_int($sformatf("dut%0d onehot", d),
                                int'(eq[d]) + int'(gt[d]) + int'(lt[d]), 1);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn);
        @(negedge clk);
        a_in[d] = a;
        b_in[d] = b;
        sg[d]   = sgn;
        st[d]   = 1'b1;
        @(posedge clk);
        #1;
        st[d]   = 1'b0;
        a_in[d] = $urandom;
        b_in[d] = $urandom;
        sg[d]   = 1'($urandom);
    endtask

    task automatic wait_done(input int d, input bit noise, output int cnt);
        bit got;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (dn[d]) got = 1'b1;
            else if (noise) st[d] = (cnt < 4);
        end
        st[d] = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d done timeout: got no done_o, expected one within 200 cycles", d);
        end
    endtask

    task automatic run(input string name, input int d, input logic [31:0] a,
                       input logic [31:0] b, input logic sgn,
                       input int exp_lat, input int exp_f, input bit noise);
        int cnt;
        start_op(d, a, b, sgn);
        wait_done(d, noise, cnt);
        if (exp_lat >= 0) chk_int({name, " latency"}, cnt, exp_lat);
        if (exp_f >= 0)   chk_int({name, " flags"}, int'({eq[d], gt[d], lt[d]}), exp_f);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0] f;
        int lat, cnt, pulses;
        logic [31:0] ra, rb;

        // Pin the reference model with hand-computed values.
        ref_cmp(8, 32'h80, 32'h7F, 1'b1, 1'b1, f, lat);
        chk_int("model 80/7F signed flags", int'(f), 3'b001);
        chk_int("model 80/7F signed lat", lat, 1);
        ref_cmp(8, 32'h01, 32'h02, 1'b0, 1'b1, f, lat);
        chk_int("model 01/02 flags", int'(f), 3'b001);
        chk_int("model 01/02 lat", lat, 7);
        ref_cmp(8, 32'hFF, 32'h01, 1'b0, 1'b0, f, lat);
        chk_int("model FF/01 unsigned flags", int'(f), 3'b010);
        chk_int("model FF/01 full lat", lat, 8);

        repeat (2) @(negedge clk);
        // Reset state
        for (int d = 0; d < 3; d++)
            chk_int($sformatf("reset dut%0d rdy/done/eq/gt/lt", d),
                    int'({rdy[d], dn[d], eq[d], gt[d], lt[d]}), 5'b10000);
        rst = 1'b0;

        // Directed cases
        run("5A==5A full",        0, 32'h5A, 32'h5A, 1'b0, 8, 3'b100, 1'b0);
        run("80>7F early",        1, 32'h80, 32'h7F, 1'b0, 1, 3'b010, 1'b0);
        run("01<02 early",        1, 32'h01, 32'h02, 1'b0, 7, 3'b001, 1'b0);
        run("FF<01 signed early", 1, 32'hFF, 32'h01, 1'b1, 1, 3'b001, 1'b0);
        run("FF>01 unsigned",     1, 32'hFF, 32'h01, 1'b0, 1, 3'b010, 1'b0);
        run("80<7F signed",       1, 32'h80, 32'h7F, 1'b1, 1, 3'b001, 1'b0);
        run("FF<01 signed full",  0, 32'hFF, 32'h01, 1'b1, 8, 3'b001, 1'b0);
        run("C3>C2 early",        1, 32'hC3, 32'hC2, 1'b0, 8, 3'b010, 1'b0);
        run("start noise in RUN", 0, 32'h10, 32'h20, 1'b0, 8, 3'b001, 1'b1);

        // Back-to-back: restart in the DONE cycle, old result must hold.
        run("b2b first",          1, 32'h40, 32'h3F, 1'b0, 2, 3'b010, 1'b0);
        start_op(1, 32'h05, 32'h06, 1'b0);
        chk_int("b2b hold flags", int'({eq[1], gt[1], lt[1]}), 3'b010);
        chk_int("b2b busy ready", int'(rdy[1]), 0);
        chk_int("b2b no done", int'(dn[1]), 0);
        wait_done(1, 1'b0, cnt);
        chk_int("b2b second latency", cnt, 7);
        chk_int("b2b second flags", int'({eq[1], gt[1], lt[1]}), 3'b001);

        // Reset in the middle of a compare.
        start_op(0, 32'h33, 32'h34, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_int("mid-run reset rdy/done/eq/gt/lt",
                int'({rdy[0], dn[0], eq[0], gt[0], lt[0]}), 5'b10000);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn[0]) pulses++;
        end
        chk_int("no done after reset", pulses, 0);

        // Randomized 8-bit traffic on both 8-bit instances.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom & 32'hFF;
            rb = ($urandom_range(0, 7) == 0) ? ra : ($urandom & 32'hFF);
            run("rand full8", 0, ra, rb, 1'($urandom), -1, -1, 1'b0);
            ra = $urandom & 32'hFF;
            rb = ($urandom_range(0, 5) == 0) ? ra : ra ^ (32'h1 << $urandom_range(0, 7));
            run("rand early8", 1, ra, rb, 1'($urandom), -1, -1, 1'b0);
        end

        // 32-bit full-length: latency always 32.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 9) == 0) ? ra : $urandom;
            run("rand full32", 2, ra, rb, 1'(i & 1), 32, -1, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
